vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync pulse pixels.
REQ-004 Parameter H_BP, default 48: horizontal back-porch pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10 / V_SYNC, default 2 / V_BP, default 33: vertical front porch, sync and back porch, in lines.
REQ-007 Port Clk  input  1: 50 MHz system clock, the only clock.
REQ-008 Port Reset_n  input  1: asynchronous, active-low reset.
REQ-009 Port vga_clk  output  1: pixel clock, Clk/2, driven from a register.
REQ-010 Port hs  output  1: horizontal sync, active low.
REQ-011 Port vs  output  1: vertical sync, active low.
REQ-012 Port blank  output  1: display enable; 1 inside the visible area, 0 otherwise (downstream drawing stage gates colour on blank=1).
REQ-013 Port sync  output  1: composite sync, tied to 0.
REQ-014 Port DrawX  output  10: current pixel column.
REQ-015 Port DrawY  output  10: current line.
REQ-016 Port frame_start  output  1: one-Clk pulse when the counters wrap to (0,0).

Function
REQ-017 vga_clk SHALL toggle on every Clk rising edge.
REQ-018 A pixel tick SHALL be the Clk edge where vga_clk goes 0->1; counters and all timing outputs update only on pixel ticks.
REQ-019 Horizontal counter hc SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800), then wrap to 0.
REQ-020 Vertical counter vc SHALL increment only on a tick where hc wraps, count 0..V_TOTAL-1 (V_TOTAL = 525), then wrap to 0.
REQ-021 DrawX SHALL equal hc and DrawY SHALL equal vc, driven from registers with no added latency.
REQ-022 hs SHALL be 0 exactly when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-023 vs SHALL be 0 exactly when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-024 blank SHALL be 1 exactly when hc < H_ACTIVE and vc < V_ACTIVE.
REQ-025 hs, vs and blank SHALL be registered, computed from the next counter values, so they change on the same Clk edge as DrawX/DrawY.
REQ-026 frame_start SHALL be 1 for exactly the one Clk cycle following the tick on which (hc,vc) becomes (0,0), and 0 at all other times.
REQ-027 The horizontal and vertical wrap SHALL occur on the same tick: (799,524) -> (0,0).
REQ-028 Counter widths SHALL be 10 bits; values >= total SHALL never occur.

Reset
REQ-029 While Reset_n=0: vga_clk=0, hc=0, vc=0, DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, sync=0.
REQ-030 Reset assertion SHALL take effect immediately, without waiting for a Clk edge, at any point in the frame.
REQ-031 After release, the first Clk edge SHALL set vga_clk=1 and count as a tick: hc becomes 1 and blank becomes 1, DrawY=0.
REQ-032 No frame_start pulse SHALL be produced on reset release.

Configuration
REQ-033 Macro VGA_FRAME_CNT_EN: when defined, add output frame_cnt (16-bit) that resets to 0, increments with wrap on every frame_start pulse, and updates in the same cycle as that pulse.
REQ-034 Without VGA_FRAME_CNT_EN, the frame_cnt port and its logic SHALL not exist; all other behaviour is unchanged.

Verification
REQ-035 Reset released, run 1600 Clk -> exactly 800 ticks, hc back at 0, DrawY=1, vga_clk period 2 Clk.
REQ-036 Line scan -> blank=1 for hc 0..639, hs=0 for hc 656..751 only (96 pixels), hs=1 elsewhere.
REQ-037 Full frame (840000 Clk) -> vs=0 only for vc 490..491, blank=0 for vc 480..524, one frame_start pulse at (0,0).
REQ-038 Boundary -> (799,524) followed by (0,0) on the next tick; (799,10) followed by (0,11).
REQ-039 Reset_n pulsed low mid-line at (300,200) -> all outputs take reset values asynchronously; after release the scan restarts from (0,0).
REQ-040 VGA_FRAME_CNT_EN defined, 3 frames run -> frame_cnt reads 1, 2, 3 at successive frame_start pulses; with 0xFFFF preloaded by forcing, the next pulse gives 0x0000.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose
//   Generates VGA raster timing from a single system clock. The pixel clock
//   runs at Clk/2. Each Clk edge where vga_clk rises is a "pixel tick", and the
//   raster counters and every timing output update only on those ticks.
//
// Ports
//   Clk          in   system clock, the only clock in the block
//   Reset_n      in   asynchronous active-low reset
//   vga_clk      out  pixel clock (Clk/2), driven from a register
//   hs           out  horizontal sync, active low
//   vs           out  vertical sync, active low
//   blank        out  display enable, 1 inside the visible area
//   sync         out  composite sync, tied to 0
//   DrawX        out  current pixel column (10 bits)
//   DrawY        out  current line (10 bits)
//   frame_start  out  one-Clk pulse after the counters wrap to (0,0)
//   frame_cnt    out  16-bit frame counter (only when VGA_FRAME_CNT_EN is defined)
//
// Configuration
//   VGA_FRAME_CNT_EN : when defined, adds the frame_cnt output and its counter.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        vga_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       vga_clk_q, vga_clk_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       tick;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  // A tick is the edge on which vga_clk goes 0->1, i.e. while it is still 0.
  assign tick = ~vga_clk_q;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    vga_clk_d     = ~vga_clk_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    frame_start_d = 1'b0;

    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end

      // Decode from the next counter values so the timing outputs change on
      // the same edge as DrawX/DrawY instead of one pixel late.
      hs_d          = ~((hc_d >= HS_START) && (hc_d < HS_END));
      vs_d          = ~((vc_d >= VS_START) && (vc_d < VS_END));
      blank_d       = (hc_d < H_VIS) && (vc_d < V_VIS);
      frame_start_d = (hc_d == '0) && (vc_d == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Advances on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vga_clk_q     <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vga_clk_q     <= vga_clk_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign vga_clk     = vga_clk_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sync        = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_start_q;

endmodule
